mux_arb_val_rdy: RTL

//  Parametrised N-input, W-bit arbitrating mux with val/rdy handshakes on all

---
 rtl/mux_arb_val_rdy.sv | 118 +++++++++++
 1 files changed

// File: rtl/mux_arb_val_rdy.sv
// mux_arb_val_rdy: N-input, W-bit arbitrating mux with val/rdy handshakes
// and a one-entry registered output stage.
// Build option MUX_ARB_VAL_RDY_RR_EN:
//   defined   -> round-robin arbitration with a priority pointer register.
//   undefined -> fixed priority, where the lowest asserted index wins.
module mux_arb_val_rdy #(
  parameter int p_nbits = 8,
  parameter int p_nreqs = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [p_nreqs-1:0]           in_val,
  output logic [p_nreqs-1:0]           in_rdy,
  input  logic [p_nreqs*p_nbits-1:0]   in_msg,
  output logic                         out_val,
  input  logic                         out_rdy,
  output logic [p_nbits-1:0]           out_msg,
  output logic [$clog2(p_nreqs)-1:0]   out_src
);

  localparam int c_sbits = $clog2(p_nreqs);

  logic                 out_val_q, out_val_d;
  logic [p_nbits-1:0]   out_msg_q, out_msg_d;
  logic [c_sbits-1:0]   out_src_q, out_src_d;
  logic [c_sbits-1:0]   ptr;
  logic [c_sbits:0]     pick_res;
  logic                 gnt_any;
  logic [c_sbits-1:0]   gnt_idx;
  logic [p_nreqs-1:0]   grant;
  logic                 can_load;
  logic                 in_xfer;
  logic                 out_xfer;

  // Return {found, index} of the first asserted valid, scanning upward
  // from the start index and wrapping past the top channel.
  function automatic logic [c_sbits:0] pick_first(
    input logic [c_sbits-1:0] start,
    input logic [p_nreqs-1:0] val
  );
    logic [c_sbits:0] res;
    int               idx;
    res = '0;
    // Scan from the farthest offset down so the nearest match is kept.
    for (int k = p_nreqs - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % p_nreqs;
      if (val[idx]) res = {1'b1, c_sbits'(idx)};
    end
    return res;
  endfunction

`ifdef MUX_ARB_VAL_RDY_RR_EN
  logic [c_sbits-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  assign pick_res = pick_first(ptr, in_val);
  assign gnt_any  = pick_res[c_sbits];
  assign gnt_idx  = pick_res[c_sbits-1:0];
  assign can_load = !out_val_q || out_rdy;
  assign in_xfer  = gnt_any && can_load && !reset;
  assign out_xfer = out_val_q && out_rdy;

  // Form the one-hot grant and gate it into per-channel ready.
  always_comb begin
    grant = '0;
    if (gnt_any) grant[gnt_idx] = 1'b1;
    in_rdy = (can_load && !reset) ? grant : '0;
  end

  // Compute the next output-register contents and arbitration pointer.
  always_comb begin
    out_val_d = out_val_q;
    out_msg_d = out_msg_q;
    out_src_d = out_src_q;
`ifdef MUX_ARB_VAL_RDY_RR_EN
    ptr_d     = ptr_q;
`endif
    if (in_xfer) begin
      out_val_d = 1'b1;
      out_msg_d = in_msg[int'(gnt_idx)*p_nbits +: p_nbits];
      out_src_d = gnt_idx;
`ifdef MUX_ARB_VAL_RDY_RR_EN
      // The pointer moves only on an accepted input, so a stalled grant keeps its place.
      if (int'(gnt_idx) == p_nreqs - 1) ptr_d = '0;
      else                               ptr_d = gnt_idx + c_sbits'(1);
`endif
    end else if (out_xfer) begin
      out_val_d = 1'b0;
    end
  end

  // State registers; reset clears the held message and the pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_val_q <= 1'b0;
      out_msg_q <= '0;
      out_src_q <= '0;
`ifdef MUX_ARB_VAL_RDY_RR_EN
      ptr_q     <= '0;
`endif
    end else begin
      out_val_q <= out_val_d;
      out_msg_q <= out_msg_d;
      out_src_q <= out_src_d;
`ifdef MUX_ARB_VAL_RDY_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign out_val = out_val_q;
  assign out_msg = out_msg_q;
  assign out_src = out_src_q;

endmodule
